// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NSTAGES subsystem resets in order with a programmable gap.
// Define RSTSEQ_ACK_EN to wait for a per-stage init-complete ack (with timeout) before moving on.
module reset_sequencer #(
   parameter int NSTAGES     = 4,
   parameter int HOLD_CYCLES = 4,
   parameter int DELAY       = 16,
   parameter int TIMEOUT     = 1024
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               swrst_req,
   input  logic [NSTAGES-1:0] stage_ack,
   output logic [NSTAGES-1:0] stage_reset,
   output logic [3:0]         cur_stage,
   output logic               seq_done,
   output logic               timeout_err
);

   localparam int HD_MAX = (HOLD_CYCLES > DELAY) ? HOLD_CYCLES : DELAY;
`ifdef RSTSEQ_ACK_EN
   localparam int CNT_MAX = (HD_MAX > TIMEOUT) ? HD_MAX : TIMEOUT;
`else
   localparam int CNT_MAX = HD_MAX;
`endif
   localparam int         CW   = $clog2(CNT_MAX + 1);
   localparam logic [3:0] LAST = 4'(NSTAGES - 1);

`ifdef RSTSEQ_ACK_EN
   typedef enum logic [1:0] {
      S_HOLD,
      S_WAIT_DELAY,
      S_WAIT_ACK,
      S_DONE
   } state_t;
`else
   typedef enum logic [1:0] {
      S_HOLD,
      S_WAIT_DELAY,
      S_DONE
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NSTAGES-1:0] rst_q, rst_d;
   logic [3:0]         cur_q, cur_d;
   logic               done_q, done_d;
   logic [NSTAGES-1:0] release_mask;

`ifdef RSTSEQ_ACK_EN
   logic terr_q, terr_d;
   logic ack_sel;
`else
   logic unused_noack;
   assign unused_noack = (^stage_ack) ^ (TIMEOUT > 0);
`endif

   // Release mask covers every stage up to and including the current one, so
   // a release can never leave a lower-index stage still in reset.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves
      // a combinational output unassigned and no latch is inferred.
      release_mask = '0;
`ifdef RSTSEQ_ACK_EN
      ack_sel = 1'b0;
`endif
      for (int k = 0; k < NSTAGES; k++) begin
         release_mask[k] = (4'(k) <= cur_q);
`ifdef RSTSEQ_ACK_EN
         if (4'(k) == cur_q) ack_sel = stage_ack[k];
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      cur_d   = cur_q;
      done_d  = done_q;
`ifdef RSTSEQ_ACK_EN
      terr_d  = terr_q;
`endif
      if (swrst_req) begin
         // Warm reset outranks every in-flight event, including a same-cycle timeout.
         state_d = S_HOLD;
         cnt_d   = '0;
         rst_d   = '1;
         cur_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                  state_d = S_WAIT_DELAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_WAIT_DELAY: begin
               if (cnt_q == CW'(DELAY - 1)) begin
                  rst_d = rst_q & ~release_mask;
                  cnt_d = '0;
`ifdef RSTSEQ_ACK_EN
                  state_d = S_WAIT_ACK;
`else
                  if (cur_q == LAST) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     cur_d = cur_q + 4'd1;
                  end
`endif
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
`ifdef RSTSEQ_ACK_EN
            S_WAIT_ACK: begin
               if (ack_sel || (cnt_q == CW'(TIMEOUT - 1))) begin
                  if (!ack_sel) terr_d = 1'b1;
                  cnt_d = '0;
                  if (cur_q == LAST) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_WAIT_DELAY;
                     cur_d   = cur_q + 4'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
`endif
            S_DONE: begin
               rst_d = '0;
               cur_d = LAST;
            end
            default: begin
               state_d = S_HOLD;
               cnt_d   = '0;
               rst_d   = '1;
               cur_d   = '0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_HOLD;
         cnt_q   <= '0;
         rst_q   <= '1;
         cur_q   <= '0;
         done_q  <= 1'b0;
`ifdef RSTSEQ_ACK_EN
         terr_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge
         // values computed by the combinational block.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         cur_q   <= cur_d;
         done_q  <= done_d;
`ifdef RSTSEQ_ACK_EN
         terr_q  <= terr_d;
`endif
      end
   end

   assign stage_reset = rst_q;
   assign cur_stage   = cur_q;
   assign seq_done    = done_q;
`ifdef RSTSEQ_ACK_EN
   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a timeline model derives every stage's release
// and completion edge from ack latencies; follows RSTSEQ_ACK_EN like the design.
module tb_reset_sequencer;

   localparam int NST = 4;
   localparam int H   = 4;
   localparam int D   = 16;
   localparam int TO  = 1024;

`ifdef RSTSEQ_ACK_EN
   localparam int EXP_OFF [NST] = '{20, 37, 54, 71};
   localparam int EXP_DONE_OFF  = 72;
   localparam logic EXP_TERR_C  = 1'b1;
`else
   localparam int EXP_OFF [NST] = '{20, 36, 52, 68};
   localparam int EXP_DONE_OFF  = 68;
   localparam logic EXP_TERR_C  = 1'b0;
`endif

   logic           clk;
   logic           resetn;
   logic           swrst_req;
   logic [NST-1:0] stage_ack;
   logic [NST-1:0] stage_reset;
   logic [3:0]     cur_stage;
   logic           seq_done;
   logic           timeout_err;

   reset_sequencer #(
      .NSTAGES     (NST),
      .HOLD_CYCLES (H),
      .DELAY       (D),
      .TIMEOUT     (TO)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .swrst_req   (swrst_req),
      .stage_ack   (stage_ack),
      .stage_reset (stage_reset),
      .cur_stage   (cur_stage),
      .seq_done    (seq_done),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Timeline of the current pass, in absolute edge numbers.
   int e      = 0;
   int s_edge = 0;
   int lat    [NST];
   int rel    [NST];
   int cmp    [NST];
   int ack_at [NST];
   bit tmo    [NST];
   bit terr_hist = 1'b0;
   int first_low [NST];
   int first_done = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void plan();
      int t, j;
      t = s_edge + H;
      for (int k = 0; k < NST; k++) begin
`ifdef RSTSEQ_ACK_EN
         rel[k]    = t + D;
         ack_at[k] = rel[k] + lat[k];
         j         = (lat[k] < 1) ? 1 : lat[k];
         tmo[k]    = (j > TO);
         cmp[k]    = rel[k] + ((j > TO) ? TO : j);
         t         = cmp[k];
`else
         rel[k]    = s_edge + H + (k + 1) * D;
         cmp[k]    = rel[k];
         tmo[k]    = 1'b0;
         ack_at[k] = 0;
`endif
      end
   endfunction

   function automatic logic [31:0] expect_word(input int ee);
      logic [NST-1:0] r;
      int  cur;
      bit  d, te;
      te = terr_hist;
      r  = '1;
      cur = 0;
      d  = 1'b0;
      if (ee > s_edge) begin
         for (int k = 0; k < NST; k++) begin
            r[k] = (ee < rel[k]);
            if (cmp[k] <= ee) begin
               cur++;
               if (tmo[k]) te = 1'b1;
            end
         end
         if (cur > NST - 1) cur = NST - 1;
         d = (ee >= cmp[NST-1]);
      end
      return 32'({te, d, 4'(cur), r});
   endfunction

   function automatic logic [31:0] dut_word();
      return 32'({timeout_err, seq_done, cur_stage, stage_reset});
   endfunction

   function automatic void clear_firsts();
      for (int k = 0; k < NST; k++) first_low[k] = -1;
      first_done = -1;
   endfunction

   task automatic new_lats(input bit allow_tmo);
      int r;
      for (int k = 0; k < NST; k++) begin
         r = int'($urandom_range(0, 99));
         if (allow_tmo && r < 8)       lat[k] = TO + int'($urandom_range(1, 20));
         else if (allow_tmo && r < 12) lat[k] = TO;
         else if (r < 35)              lat[k] = -int'($urandom_range(0, 30));
         else                          lat[k] = int'($urandom_range(1, 40));
      end
   endtask

   task automatic all_acks_high();
      for (int k = 0; k < NST; k++) lat[k] = -1000;
   endtask

   // One clock edge: drive inputs, advance the model, compare all outputs after the edge.
   task automatic step(input bit sw);
      swrst_req = sw;
`ifdef RSTSEQ_ACK_EN
      for (int k = 0; k < NST; k++) stage_ack[k] = (e + 1 >= ack_at[k]);
`else
      stage_ack = NST'($urandom);
`endif
      @(posedge clk);
      e++;
      if (sw) begin
         for (int k = 0; k < NST; k++)
            if (tmo[k] && cmp[k] < e) terr_hist = 1'b1;
         s_edge = e;
         plan();
         clear_firsts();
      end
      #1;
      check($sformatf("cyc%0d", e), dut_word(), expect_word(e));
      for (int k = 0; k < NST; k++)
         if (first_low[k] < 0 && stage_reset[k] == 1'b0) first_low[k] = e;
      if (first_done < 0 && seq_done) first_done = e;
   endtask

   task automatic run_to_done();
      int stop;
      stop = cmp[NST-1] + 3;
      while (e < stop) step(1'b0);
   endtask

   task automatic check_offsets(input string tag);
      for (int k = 0; k < NST; k++)
         check($sformatf("%s_rel%0d", tag, k), 32'(first_low[k] - s_edge), 32'(EXP_OFF[k]));
      check($sformatf("%s_done", tag), 32'(first_done - s_edge), 32'(EXP_DONE_OFF));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=%0d exp=finished", e);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p_edge, hold;
      resetn    = 1'b0;
      swrst_req = 1'b0;
      stage_ack = '0;
      all_acks_high();
      clear_firsts();
      repeat (3) @(posedge clk);
      #1;
      check("por", dut_word(), 32'({1'b0, 1'b0, 4'd0, {NST{1'b1}}}));

      // Power-on pass, acks held high throughout.
      @(negedge clk);
      resetn = 1'b1;
      s_edge = e;
      plan();
      run_to_done();
      check_offsets("por_pass");

      // Single-cycle warm reset from DONE repeats the same offsets.
      step(1'b1);
      check("swrst_rst", 32'(stage_reset), 32'({NST{1'b1}}));
      check("swrst_cur", 32'(cur_stage), 32'd0);
      check("swrst_done", 32'(seq_done), 32'd0);
      run_to_done();
      check_offsets("warm_pass");

      // Stage 1 never acks in time.
      new_lats(1'b0);
      lat[1] = TO + 7;
      step(1'b1);
      run_to_done();
      check("tmo_err", 32'(timeout_err), 32'(EXP_TERR_C));
      check("tmo_done", 32'(seq_done), 32'd1);

      // Warm reset must not clear the sticky error.
      new_lats(1'b0);
      step(1'b1);
      check("tmo_sticky", 32'(timeout_err), 32'(EXP_TERR_C));
      run_to_done();

      // swrst_req and stage 2 ack arrive on the same edge.
      new_lats(1'b0);
      lat[2] = int'($urandom_range(1, 20));
      step(1'b1);
      p_edge = rel[2] + lat[2];
      while (e + 1 < p_edge) step(1'b0);
      step(1'b1);
      check("sw_vs_ack_rst", 32'(stage_reset), 32'({NST{1'b1}}));
      check("sw_vs_ack_cur", 32'(cur_stage), 32'd0);
      run_to_done();

      // Asynchronous reset between edges, mid-sequence.
      new_lats(1'b0);
      step(1'b1);
      repeat (int'($urandom_range(25, 60))) step(1'b0);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst", dut_word(), 32'({1'b0, 1'b0, 4'd0, {NST{1'b1}}}));
      repeat (2) @(posedge clk);
      @(negedge clk);
      swrst_req = 1'b0;
      resetn    = 1'b1;
      terr_hist = 1'b0;
      s_edge    = e;
      plan();
      clear_firsts();
      run_to_done();
      check("async_terr", 32'(timeout_err), 32'd0);

      // Random passes: random ack latencies, warm-reset lengths and abort points.
      for (int p = 0; p < 8; p++) begin
         new_lats(p < 2);
         hold = int'($urandom_range(1, 3));
         for (int h = 0; h < hold; h++) step(1'b1);
         if ($urandom_range(0, 1) == 1) begin
            p_edge = s_edge + int'($urandom_range(1, cmp[NST-1] - s_edge));
            while (e + 1 < p_edge) step(1'b0);
         end else begin
            run_to_done();
         end
      end
      run_to_done();
      check("final_done", 32'(seq_done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
